// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types and encodings
package mips_pkg;

  localparam int REG_W = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // E-stage control bundle, also carried forward by the EX/MEM stage
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_t;

endpackage

// File: rtl/id_ex_hazard.sv
// rtl/id_ex_hazard.sv - combinational load-use and branch-compare stall detection
module id_ex_hazard
  import mips_pkg::*;
(
  input  logic             validD,
  input  logic             branchD,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic             validE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic             memtoregM,
  input  logic [REG_W-1:0] writeregM,
  output logic             lwstall,
  output logic             branchstall
);

  logic bsE;
  logic bsM;

  assign lwstall = validD & validE & memtoregE & (rtE != '0) &
                   ((rtE == rsD) | (rtE == rtD));

  // The branch comparator sits in D, so an in-flight result for either operand must land first
  assign bsE = validE & regwriteE & (writeregE != '0) &
               ((writeregE == rsD) | (writeregE == rtD));
  assign bsM = memtoregM & (writeregM != '0) &
               ((writeregM == rsD) | (writeregM == rtD));

  assign branchstall = validD & branchD & (bsE | bsM);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with stall/bubble control and stall counter
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validD,
  input  logic              regwriteD,
  input  logic              memtoregD,
  input  logic              memwriteD,
  input  logic              alusrcD,
  input  logic              regdstD,
  input  logic              branchD,
  input  logic [2:0]        alucontrolD,
  input  logic [DATA_W-1:0] rd1D,
  input  logic [DATA_W-1:0] rd2D,
  input  logic [DATA_W-1:0] signimmD,
  input  logic [REG_W-1:0]  rsD,
  input  logic [REG_W-1:0]  rtD,
  input  logic [REG_W-1:0]  rdD,
  input  logic              flushE,
  input  logic [REG_W-1:0]  writeregM,
  input  logic              memtoregM,
  output logic              validE,
  output logic              regwriteE,
  output logic              memtoregE,
  output logic              memwriteE,
  output logic              alusrcE,
  output logic [2:0]        alucontrolE,
  output logic [DATA_W-1:0] rd1E,
  output logic [DATA_W-1:0] rd2E,
  output logic [DATA_W-1:0] signimmE,
  output logic [REG_W-1:0]  rsE,
  output logic [REG_W-1:0]  rtE,
  output logic [REG_W-1:0]  rdE,
  output logic [REG_W-1:0]  writeregE,
  output logic              stallF,
  output logic              stallD,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t            ctrlD;
  ctrl_t            ctrlE;
  logic             lwstall;
  logic             branchstall;
  logic             bubble;
  logic [CNT_W-1:0] stallCnt;

  assign ctrlD = '{regwrite:   regwriteD,
                   memtoreg:   memtoregD,
                   memwrite:   memwriteD,
                   alusrc:     alusrcD,
                   regdst:     regdstD,
                   alucontrol: alucontrolD};

  id_ex_hazard u_hazard (
    .validD      (validD),
    .branchD     (branchD),
    .rsD         (rsD),
    .rtD         (rtD),
    .validE      (validE),
    .regwriteE   (ctrlE.regwrite),
    .memtoregE   (ctrlE.memtoreg),
    .rtE         (rtE),
    .writeregE   (writeregE),
    .memtoregM   (memtoregM),
    .writeregM   (writeregM),
    .lwstall     (lwstall),
    .branchstall (branchstall)
  );

  assign stallD = lwstall | branchstall;
  assign stallF = stallD;
  assign bubble = stallD | flushE;

  // A bubble zeroes rsE/rtE as well so the forwarding unit sees no sources
  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      validE   <= 1'b0;
      ctrlE    <= '0;
      rd1E     <= '0;
      rd2E     <= '0;
      signimmE <= '0;
      rsE      <= '0;
      rtE      <= '0;
      rdE      <= '0;
    end else begin
      validE   <= validD;
      ctrlE    <= ctrlD;
      rd1E     <= rd1D;
      rd2E     <= rd2D;
      signimmE <= signimmD;
      rsE      <= rsD;
      rtE      <= rtD;
      rdE      <= rdD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stallD && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign regwriteE   = ctrlE.regwrite;
  assign memtoregE   = ctrlE.memtoreg;
  assign memwriteE   = ctrlE.memwrite;
  assign alusrcE     = ctrlE.alusrc;
  assign alucontrolE = ctrlE.alucontrol;
  assign writeregE   = ctrlE.regdst ? rdE : rtE;
  assign stall_cnt   = stallCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          validD, regwriteD, memtoregD, memwriteD, alusrcD, regdstD, branchD;
  logic [2:0]    alucontrolD;
  logic [DW-1:0] rd1D, rd2D, signimmD;
  logic [4:0]    rsD, rtD, rdD;
  logic          flushE;
  logic [4:0]    writeregM;
  logic          memtoregM;
  logic          validE, regwriteE, memtoregE, memwriteE, alusrcE;
  logic [2:0]    alucontrolE;
  logic [DW-1:0] rd1E, rd2E, signimmE;
  logic [4:0]    rsE, rtE, rdE, writeregE;
  logic          stallF, stallD;
  logic [CW-1:0] stall_cnt;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .validD(validD), .regwriteD(regwriteD),
    .memtoregD(memtoregD), .memwriteD(memwriteD), .alusrcD(alusrcD),
    .regdstD(regdstD), .branchD(branchD), .alucontrolD(alucontrolD),
    .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD), .rsD(rsD), .rtD(rtD),
    .rdD(rdD), .flushE(flushE), .writeregM(writeregM), .memtoregM(memtoregM),
    .validE(validE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .memwriteE(memwriteE), .alusrcE(alusrcE), .alucontrolE(alucontrolE),
    .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE), .rsE(rsE), .rtE(rtE),
    .rdE(rdE), .writeregE(writeregE), .stallF(stallF), .stallD(stallD),
    .stall_cnt(stall_cnt)
  );

  // ld: E holds a captured D slot (not reset, not a bubble)
  typedef struct {
    logic          ld, vE, rwE, mtrE;
    logic [4:0]    rsE, rtE, wrE;
    logic [DW-1:0] d1E;
    logic          st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t mon;
  int   nRun  = 0;
  int   nFail = 0;
  int   row   = 0;

  task automatic chk(input int r, input string nm, input logic [31:0] act, input logic [31:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL row %0d %s: got %h expected %h", r, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      mon = expQ.pop_front();
      chk(row, "validE",      validE,      mon.vE);
      chk(row, "regwriteE",   regwriteE,   mon.rwE);
      chk(row, "memtoregE",   memtoregE,   mon.mtrE);
      chk(row, "memwriteE",   memwriteE,   mon.ld);
      chk(row, "alusrcE",     alusrcE,     mon.ld);
      chk(row, "alucontrolE", alucontrolE, mon.ld ? ALU_ADD : 3'b000);
      chk(row, "rsE",         rsE,         mon.rsE);
      chk(row, "rtE",         rtE,         mon.rtE);
      chk(row, "writeregE",   writeregE,   mon.wrE);
      chk(row, "rd1E",        rd1E,        mon.d1E);
      chk(row, "rd2E",        rd2E,        mon.ld ? mon.d1E + 32'h11 : 32'h0);
      chk(row, "signimmE",    signimmE,    mon.ld ? 32'hFFFF_FFF0 : 32'h0);
      chk(row, "stallD",      stallD,      mon.st);
      chk(row, "stallF",      stallF,      mon.st);
      chk(row, "stall_cnt",   stall_cnt,   mon.cnt);
      row++;
    end
  end

  // Apply one cycle of D/M inputs and queue the outputs expected before the next edge
  task automatic cyc(input logic rstn, vD, rw, mtr, rdst, br,
                     input logic [4:0] rs, rt, rd, input logic [31:0] d1,
                     input logic fl, mtrM, input logic [4:0] wrM,
                     input logic ld, vE, rwE, mtrE, input logic [4:0] rsE_x, rtE_x, wrE_x,
                     input logic [31:0] d1E, input logic st, input logic [CW-1:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstn; validD = vD; regwriteD = rw; memtoregD = mtr; regdstD = rdst;
    branchD = br; rsD = rs; rtD = rt; rdD = rd; rd1D = d1; rd2D = d1 + 32'h11;
    memwriteD = 1'b1; alusrcD = 1'b1; alucontrolD = ALU_ADD; signimmD = 32'hFFFF_FFF0;
    flushE = fl; memtoregM = mtrM; writeregM = wrM;
    e.ld = ld; e.vE = vE; e.rwE = rwE; e.mtrE = mtrE;
    e.rsE = rsE_x; e.rtE = rtE_x; e.wrE = wrE_x; e.d1E = d1E; e.st = st; e.cnt = cnt;
    expQ.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; validD = 1'b1; regwriteD = 1'b1; memtoregD = 1'b1; memwriteD = 1'b1;
    alusrcD = 1'b1; regdstD = 1'b1; branchD = 1'b1; alucontrolD = 3'b111;
    rd1D = '1; rd2D = '1; signimmD = '1; rsD = 5'd31; rtD = 5'd31; rdD = 5'd31;
    flushE = 1'b0; writeregM = 5'd0; memtoregM = 1'b0;
    repeat (2) @(posedge clk);

    //   rst vD rw mt rd br  rs  rt  rd  d1        fl mM wM   ld vE rw mt rsE rtE wrE d1E       st cnt
    cyc(0, 1, 1, 1, 1, 1, 31, 31, 31, 32'hFFFF_FFFF, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  32'h0,    0, 0);
    cyc(1, 1, 1, 0, 1, 0, 3,  4,  5,  32'h11,    0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  32'h0,    0, 0);
    cyc(1, 1, 1, 1, 0, 0, 1,  8,  0,  32'h100,   0, 0, 0,  1, 1, 1, 0, 3,  4,  5,  32'h11,   0, 0);
    cyc(1, 1, 1, 0, 1, 0, 8,  2,  6,  32'h200,   0, 0, 0,  1, 1, 1, 1, 1,  8,  8,  32'h100,  1, 0);
    cyc(1, 1, 1, 0, 1, 0, 8,  2,  6,  32'h200,   0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  32'h0,    0, 1);
    cyc(1, 1, 1, 1, 0, 0, 1,  0,  0,  32'h300,   0, 0, 0,  1, 1, 1, 0, 8,  2,  6,  32'h200,  0, 1);
    cyc(1, 1, 1, 0, 1, 0, 0,  0,  7,  32'h400,   0, 0, 0,  1, 1, 1, 1, 1,  0,  0,  32'h300,  0, 1);
    cyc(1, 1, 1, 1, 0, 0, 1,  10, 0,  32'h500,   0, 0, 0,  1, 1, 1, 0, 0,  0,  7,  32'h400,  0, 1);
    cyc(1, 1, 1, 0, 1, 0, 10, 3,  11, 32'h600,   1, 0, 0,  1, 1, 1, 1, 1,  10, 10, 32'h500,  1, 1);
    cyc(1, 0, 1, 0, 1, 0, 10, 3,  11, 32'h600,   0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  32'h0,    0, 2);
    cyc(1, 1, 1, 0, 1, 0, 1,  2,  9,  32'h700,   0, 0, 0,  1, 0, 1, 0, 10, 3,  11, 32'h600,  0, 2);
    cyc(1, 1, 0, 0, 0, 1, 9,  0,  0,  32'h800,   0, 0, 0,  1, 1, 1, 0, 1,  2,  9,  32'h700,  1, 2);
    cyc(1, 1, 0, 0, 0, 1, 9,  0,  0,  32'h800,   0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  32'h0,    0, 3);
    cyc(1, 1, 1, 1, 0, 0, 1,  9,  0,  32'h900,   0, 0, 0,  1, 1, 0, 0, 9,  0,  0,  32'h800,  0, 3);
    cyc(1, 1, 0, 0, 0, 1, 9,  0,  0,  32'hA00,   0, 0, 0,  1, 1, 1, 1, 1,  9,  9,  32'h900,  1, 3);
    cyc(1, 1, 0, 0, 0, 1, 9,  0,  0,  32'hA00,   0, 1, 9,  0, 0, 0, 0, 0,  0,  0,  32'h0,    1, 4);
    cyc(1, 1, 0, 0, 0, 1, 9,  0,  0,  32'hA00,   0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  32'h0,    0, 5);
    cyc(1, 1, 1, 1, 0, 0, 1,  12, 0,  32'hB00,   0, 0, 0,  1, 1, 0, 0, 9,  0,  0,  32'hA00,  0, 5);
    cyc(1, 0, 1, 0, 1, 1, 12, 12, 13, 32'hC00,   0, 1, 12, 1, 1, 1, 1, 1,  12, 12, 32'hB00,  0, 5);
    cyc(1, 1, 0, 0, 0, 1, 9,  0,  0,  32'hD00,   0, 1, 9,  1, 0, 1, 0, 12, 12, 13, 32'hC00,  1, 5);
    for (int i = 1; i < 20; i++)
      cyc(1, 1, 0, 0, 0, 1, 9, 0, 0, 32'hD00, 0, 1, 9,
          0, 0, 0, 0, 0, 0, 0, 32'h0, 1, CW'((5 + i > 15) ? 15 : 5 + i));
    cyc(0, 1, 0, 0, 0, 1, 9,  0,  0,  32'hD00,   0, 1, 9,  0, 0, 0, 0, 0,  0,  0,  32'h0,    1, 15);
    cyc(1, 0, 0, 0, 0, 0, 0,  0,  0,  32'h0,     0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  32'h0,    0, 0);

    repeat (3) @(posedge clk);
    nRun++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d expected entries left, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
